mel_log: RTL and testbench
==========================

Name: mel_log

Overview:
- Log-compression stage directly downstream of the mel filterbank; final arithmetic stage before frame output.
- Accepts one packed frame of N_BINS mel energies per di_en pulse and buffers it, with one pending slot.
- Emits one signed fixed-point log2 value per cycle as a serial stream tagged with bin index and frame markers.

Parameters:
- I_BW, 14, width of each signed mel bin in the input vector.
- O_BW, 16, width of signed log output; format Q(O_BW-FRAC_BW).FRAC_BW.
- FRAC_BW, 8, fractional bits of log2 output.
- N_BINS, 64, mel bins per frame.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- data_i  in  I_BW*N_BINS  packed frame; bin i at bits [(N_BINS-1-i)*I_BW +: I_BW], so bin 0 is in the MSBs.
- di_en  in  1  one-cycle pulse; data_i and in_group_num are valid.
- in_group_num  in  7  frame tag, 0-88.
- data_o  out  O_BW  signed log2 result.
- do_en  out  1  data_o valid.
- bin_idx  out  6  bin index of data_o.
- is_first_out  out  1  high with bin 0.
- is_last_out  out  1  high with bin N_BINS-1.
- out_group_num  out  7  tag of the frame being emitted.
- busy  out  1  active frame or pending frame held.
- drop_o  out  1  one-cycle pulse when an incoming frame is discarded.

Behaviour:
- Reset (async on rst high): every output is 0; state is IDLE; active and pending valid flags are cleared; pipeline valids are cleared. A reset mid-frame aborts with no further do_en.
- FSM states:
  - IDLE: on di_en, capture frame and tag into the active buffer, set cnt=0, go to RUN.
  - RUN: issue bin[cnt] into the pipeline each cycle and increment cnt.
  - At cnt==N_BINS-1: if pending is valid, load active from pending and clear pending; else if di_en, load active from data_i. In either case cnt=0 and the state stays RUN. Otherwise go to IDLE.
- di_en while in RUN, outside the reload case: store into pending if pending is empty; else assert drop_o and discard the frame (pending is kept).
- Simultaneous last-issue, pending valid and di_en: pending moves to active, and the di_en frame goes to pending.
- Pipeline, 3 registered stages:
  - S1: select bin and detect non-positive value.
  - S2: leading-one position p (0..I_BW-2). Mantissa m = the 5 bits immediately below the leading one, zero-padded on the right.
  - S3: result = (p << FRAC_BW) + LUT[m], where LUT[m] = round(log2(1+m/32) * 2^FRAC_BW), 32 entries.
- Clamp: input <= 0 gives -(2^FRAC_BW), i.e. -1.0.
- Latency: di_en at cycle T (IDLE) puts bin 0 on data_o at T+4. Bins follow on consecutive cycles, with bin N_BINS-1 at T+4+N_BINS-1.
- Back-to-back frames are gapless.
- bin_idx, is_first_out, is_last_out and out_group_num travel with the data through the pipeline.
- busy: high from the cycle after capture until the last bin leaves S3 and pending is empty.
- No backpressure: the consumer must accept one sample per cycle.

Decomposition:
- Shared include file mel_log_defs.vh: N_BINS, FSM state encodings (IDLE, RUN), LUT depth 32, clamp constant.
- Sub-module log2_unit: stages S2–S3 (leading-one detect, mantissa extract, LUT, assemble). It is parameterised by I_BW, O_BW and FRAC_BW, and the LUT is a case ROM.

Test Plan:
- Single frame with bins {1, 2, 3, 8191, 8192 (max positive is 8191; drive 0x2000 as negative -8192), 0, -5, rest 1}, tag 17 -> do_en pulses on 64 consecutive cycles starting T+4. Outputs: 0, 256, 406, 3322, -256, -256, -256, then 0s. out_group_num=17; is_first_out with bin 0, is_last_out with bin 63.
- Ramp bins i -> bin 1 = 0, bin 4 = 512, bin 5 = 512+LUT[8]=512+82=594, bin 63 = 1280+LUT[31]=1280+250=1530. bin_idx matches i.
- Second di_en 10 cycles into a frame, third at cycle 20 -> second frame emitted gapless after the first (cycles T+68..T+131); third gives drop_o=1 for 1 cycle and never appears.
- di_en coincident with last issue (cnt=63), no pending -> next frame's bin 0 emitted the cycle after the prior bin 63; drop_o stays 0.
- rst asserted during bin 30 -> all outputs 0 asynchronously; no do_en after release until a new di_en, whose bin 0 appears at T+4.
- Idle (no di_en) -> do_en, busy and drop_o stay 0 for 1000 cycles.

Source files
------------

// File: rtl/mel_log_pkg.sv
// Shared constants and types for the mel log-compression stage.
package mel_log_pkg;
  localparam int unsigned BIN_W     = 6;
  localparam int unsigned GRP_W     = 7;
  localparam int unsigned TAG_W     = BIN_W + 2 + GRP_W;
  localparam int unsigned LUT_DEPTH = 32;
  localparam int unsigned MANT_W    = $clog2(LUT_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/mel_log_log2_unit.sv
// Pipeline stages S2-S3: leading-one detect and mantissa extract, then
// log2 assembly from the integer part and a 32-entry fraction ROM.
module log2_unit
  import mel_log_pkg::*;
#(
  parameter int unsigned I_BW    = 14,
  parameter int unsigned O_BW    = 16,
  parameter int unsigned FRAC_BW = 8,
  parameter int unsigned TAG_W_P = TAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   v_i,
  input  logic                   np_i,
  input  logic [I_BW-2:0]        mag_i,
  input  logic [TAG_W_P-1:0]     tag_i,
  output logic                   v_o,
  output logic signed [O_BW-1:0] y_o,
  output logic [TAG_W_P-1:0]     tag_o,
  output logic                   active_o
);
  localparam int unsigned P_W = $clog2(I_BW - 1);
  localparam logic signed [O_BW-1:0] CLAMP = -(O_BW'(1) << FRAC_BW);

  logic [P_W-1:0]    p_d, s2_p_q;
  logic [I_BW-2:0]   norm_d;
  logic [MANT_W-1:0] m_d, s2_m_q;
  logic              s2_v_q, s2_np_q;
  logic [TAG_W_P-1:0] s2_tag_q;
  logic [FRAC_BW-1:0] lut;
  logic signed [O_BW-1:0] y_d;

  always_comb begin
    p_d = '0;
    for (int unsigned i = 0; i < I_BW - 1; i++) begin
      if (mag_i[i]) p_d = P_W'(i);
    end
    // Normalise so the leading one sits at the top; the bits below it are the mantissa.
    norm_d = mag_i << (P_W'(I_BW - 2) - p_d);
    m_d    = norm_d[I_BW-3 -: MANT_W];
  end

  always_comb begin
    case (s2_m_q)
      5'd0:  lut = FRAC_BW'(0);
      5'd1:  lut = FRAC_BW'(11);
      5'd2:  lut = FRAC_BW'(22);
      5'd3:  lut = FRAC_BW'(33);
      5'd4:  lut = FRAC_BW'(44);
      5'd5:  lut = FRAC_BW'(54);
      5'd6:  lut = FRAC_BW'(63);
      5'd7:  lut = FRAC_BW'(73);
      5'd8:  lut = FRAC_BW'(82);
      5'd9:  lut = FRAC_BW'(92);
      5'd10: lut = FRAC_BW'(100);
      5'd11: lut = FRAC_BW'(109);
      5'd12: lut = FRAC_BW'(118);
      5'd13: lut = FRAC_BW'(126);
      5'd14: lut = FRAC_BW'(134);
      5'd15: lut = FRAC_BW'(142);
      5'd16: lut = FRAC_BW'(150);
      5'd17: lut = FRAC_BW'(157);
      5'd18: lut = FRAC_BW'(165);
      5'd19: lut = FRAC_BW'(172);
      5'd20: lut = FRAC_BW'(179);
      5'd21: lut = FRAC_BW'(186);
      5'd22: lut = FRAC_BW'(193);
      5'd23: lut = FRAC_BW'(200);
      5'd24: lut = FRAC_BW'(207);
      5'd25: lut = FRAC_BW'(213);
      5'd26: lut = FRAC_BW'(220);
      5'd27: lut = FRAC_BW'(226);
      5'd28: lut = FRAC_BW'(232);
      5'd29: lut = FRAC_BW'(238);
      5'd30: lut = FRAC_BW'(244);
      default: lut = FRAC_BW'(250);
    endcase
    y_d = s2_np_q ? CLAMP : (O_BW'(s2_p_q) << FRAC_BW) + O_BW'(lut);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q   <= 1'b0;
      s2_np_q  <= 1'b0;
      s2_p_q   <= '0;
      s2_m_q   <= '0;
      s2_tag_q <= '0;
      v_o      <= 1'b0;
      y_o      <= '0;
      tag_o    <= '0;
    end else begin
      s2_v_q   <= v_i;
      s2_np_q  <= np_i;
      s2_p_q   <= p_d;
      s2_m_q   <= m_d;
      s2_tag_q <= tag_i;
      v_o      <= s2_v_q;
      y_o      <= s2_v_q ? y_d : '0;
      tag_o    <= s2_v_q ? s2_tag_q : '0;
    end
  end

  assign active_o = s2_v_q | v_o;
endmodule

// File: rtl/mel_log.sv
// Log2 compression of buffered mel frames into a tagged serial stream,
// with one pending frame slot and a three-stage arithmetic pipeline.
module mel_log
  import mel_log_pkg::*;
#(
  parameter int unsigned I_BW    = 14,
  parameter int unsigned O_BW    = 16,
  parameter int unsigned FRAC_BW = 8,
  parameter int unsigned N_BINS  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [I_BW*N_BINS-1:0]   data_i,
  input  logic                     di_en,
  input  logic [GRP_W-1:0]         in_group_num,
  output logic signed [O_BW-1:0]   data_o,
  output logic                     do_en,
  output logic [BIN_W-1:0]         bin_idx,
  output logic                     is_first_out,
  output logic                     is_last_out,
  output logic [GRP_W-1:0]         out_group_num,
  output logic                     busy,
  output logic                     drop_o
);
  localparam logic [BIN_W-1:0] LAST = BIN_W'(N_BINS - 1);

  state_e                 state_q;
  logic [BIN_W-1:0]       cnt_q;
  logic [I_BW*N_BINS-1:0] act_q, pend_q;
  logic [GRP_W-1:0]       act_grp_q, pend_grp_q;
  logic                   pend_v_q, drop_q;
  logic                   s1_v_q, s1_np_q;
  logic [I_BW-2:0]        s1_mag_q;
  logic [TAG_W-1:0]       s1_tag_q, tag_o;
  logic [I_BW-1:0]        bin_sel;
  logic                   tail_active;

  assign bin_sel = act_q[(N_BINS - 1 - int'(cnt_q)) * I_BW +: I_BW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      act_q      <= '0;
      act_grp_q  <= '0;
      pend_q     <= '0;
      pend_grp_q <= '0;
      pend_v_q   <= 1'b0;
      drop_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_np_q    <= 1'b0;
      s1_mag_q   <= '0;
      s1_tag_q   <= '0;
    end else begin
      drop_q <= 1'b0;
      s1_v_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (di_en) begin
            act_q     <= data_i;
            act_grp_q <= in_group_num;
            cnt_q     <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          s1_v_q   <= 1'b1;
          s1_np_q  <= bin_sel[I_BW-1] || (bin_sel == '0);
          s1_mag_q <= bin_sel[I_BW-2:0];
          s1_tag_q <= {cnt_q, cnt_q == '0, cnt_q == LAST, act_grp_q};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            // Pending wins the reload; a coincident new frame refills the slot it vacates.
            if (pend_v_q) begin
              act_q     <= pend_q;
              act_grp_q <= pend_grp_q;
              pend_v_q  <= di_en;
              if (di_en) begin
                pend_q     <= data_i;
                pend_grp_q <= in_group_num;
              end
            end else if (di_en) begin
              act_q     <= data_i;
              act_grp_q <= in_group_num;
            end else begin
              state_q <= IDLE;
            end
          end else if (di_en) begin
            if (!pend_v_q) begin
              pend_q     <= data_i;
              pend_grp_q <= in_group_num;
              pend_v_q   <= 1'b1;
            end else begin
              drop_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  log2_unit #(
    .I_BW   (I_BW),
    .O_BW   (O_BW),
    .FRAC_BW(FRAC_BW),
    .TAG_W_P(TAG_W)
  ) u_log2 (
    .clk     (clk),
    .rst     (rst),
    .v_i     (s1_v_q),
    .np_i    (s1_np_q),
    .mag_i   (s1_mag_q),
    .tag_i   (s1_tag_q),
    .v_o     (do_en),
    .y_o     (data_o),
    .tag_o   (tag_o),
    .active_o(tail_active)
  );

  assign {bin_idx, is_first_out, is_last_out, out_group_num} = tag_o;
  assign busy   = (state_q == RUN) | pend_v_q | s1_v_q | tail_active;
  assign drop_o = drop_q;
endmodule

// File: tb/tb_mel_log.sv
// Scoreboarded bench for mel_log: table-driven frame plus timed multi-frame sequences.
module tb_mel_log;
  localparam int I_BW = 14, O_BW = 16, FRAC_BW = 8, NB = 64;

  logic                    clk, rst, di_en;
  logic [I_BW*NB-1:0]      data_i;
  logic [6:0]              in_group_num, out_group_num;
  logic signed [O_BW-1:0]  data_o;
  logic                    do_en, is_first_out, is_last_out, busy, drop_o;
  logic [5:0]              bin_idx;

  mel_log #(.I_BW(I_BW), .O_BW(O_BW), .FRAC_BW(FRAC_BW), .N_BINS(NB)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .di_en(di_en), .in_group_num(in_group_num),
    .data_o(data_o), .do_en(do_en), .bin_idx(bin_idx), .is_first_out(is_first_out),
    .is_last_out(is_last_out), .out_group_num(out_group_num), .busy(busy), .drop_o(drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic signed [15:0] d; int idx; int grp; int at; } exp_t;
  typedef struct { logic signed [13:0] x; logic signed [15:0] y; } vec_t;

  exp_t sbq[$];
  int   dropq[$];
  int   checks = 0, failures = 0;
  logic signed [13:0] frame_bins [NB];
  logic signed [15:0] exp_y [NB];
  vec_t tbl [12];

  function automatic void check(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, req);
    end
  endfunction

  function automatic logic signed [15:0] model(input logic signed [13:0] x);
    int p, m, lut;
    if (x[13] || x == 0) return -16'sd256;
    p = 0;
    for (int i = 0; i < 13; i++) if (x[i]) p = i;
    m   = ((int'(x) * 32) >> p) - 32;
    lut = int'($floor($ln(1.0 + real'(m) / 32.0) / $ln(2.0) * 256.0 + 0.5));
    return 16'(p * 256 + lut);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (do_en) begin
        if (sbq.size() == 0) check("unexpected_do_en", 1, 0);
        else begin
          e = sbq.pop_front();
          check("data_o", data_o, e.d);
          check("bin_idx", bin_idx, e.idx);
          check("is_first_out", is_first_out, e.idx == 0);
          check("is_last_out", is_last_out, e.idx == NB - 1);
          check("out_group_num", out_group_num, e.grp);
          check("out_cycle", cyc, e.at);
        end
      end else if (sbq.size() > 0 && sbq[0].at <= cyc) begin
        check("missing_do_en", 0, 1);
        void'(sbq.pop_front());
      end
      if (drop_o) begin
        if (dropq.size() == 0) check("unexpected_drop", 1, 0);
        else check("drop_cycle", cyc, dropq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill_model();
    for (int i = 0; i < NB; i++) exp_y[i] = model(frame_bins[i]);
  endtask

  // start: -1 = expect output at drive+4, -2 = expect a drop, else explicit start cycle
  task automatic drive_frame(input int tag, input int start);
    int st;
    exp_t e;
    for (int i = 0; i < NB; i++) data_i[(NB-1-i)*I_BW +: I_BW] = frame_bins[i];
    in_group_num = 7'(tag);
    di_en = 1'b1;
    if (start == -2) dropq.push_back(cyc + 1);
    else begin
      st = (start == -1) ? cyc + 4 : start;
      for (int i = 0; i < NB; i++) begin
        e.d = exp_y[i]; e.idx = i; e.grp = tag; e.at = st + i;
        sbq.push_back(e);
      end
    end
    tick();
    di_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sbq.size() > 0 && n < budget) begin tick(); n++; end
    check("drain_timeout", sbq.size(), 0);
    sbq.delete();
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_do_en"}, do_en, 0);
    check({nm, "_data_o"}, data_o, 0);
    check({nm, "_bin_idx"}, bin_idx, 0);
    check({nm, "_first"}, is_first_out, 0);
    check({nm, "_last"}, is_last_out, 0);
    check({nm, "_grp"}, out_group_num, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_drop"}, drop_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca;
    tbl[0]  = '{14'sd1,    16'sd0};
    tbl[1]  = '{14'sd2,    16'sd256};
    tbl[2]  = '{14'sd3,    16'sd406};
    tbl[3]  = '{14'sd8191, 16'sd3322};
    tbl[4]  = '{14'h2000,  -16'sd256};
    tbl[5]  = '{14'sd0,    -16'sd256};
    tbl[6]  = '{-14'sd5,   -16'sd256};
    tbl[7]  = '{14'sd4,    16'sd512};
    tbl[8]  = '{14'sd5,    16'sd594};
    tbl[9]  = '{14'sd64,   16'sd1536};
    tbl[10] = '{14'sd100,  16'sd1701};
    tbl[11] = '{14'sd4095, 16'sd3066};

    rst = 1'b1; di_en = 1'b0; data_i = '0; in_group_num = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Table frame, tag 17
    for (int i = 0; i < NB; i++) frame_bins[i] = 14'sd1;
    fill_model();
    for (int k = 0; k < 12; k++) begin
      frame_bins[k] = tbl[k].x;
      exp_y[k]      = tbl[k].y;
    end
    drive_frame(17, -1);
    check("busy_after_capture", busy, 1);
    drain(200);
    check("busy_after_frame", busy, 0);

    // Ramp, tag 5
    for (int i = 0; i < NB; i++) frame_bins[i] = 14'(i);
    fill_model();
    drive_frame(5, -1);
    drain(200);

    // Pending at +10, drop at +20, reload-with-pending-and-new at last issue
    for (int i = 0; i < NB; i++) frame_bins[i] = 14'(i * 100 + 7);
    fill_model();
    ca = cyc;
    drive_frame(1, -1);
    while (cyc < ca + 10) tick();
    for (int i = 0; i < NB; i++) frame_bins[i] = 14'($urandom);
    fill_model();
    drive_frame(2, ca + 4 + NB);
    while (cyc < ca + 20) tick();
    drive_frame(3, -2);
    while (cyc < ca + 64) tick();
    for (int i = 0; i < NB; i++) frame_bins[i] = 14'($urandom_range(1, 8191));
    fill_model();
    drive_frame(4, ca + 4 + 2 * NB);
    drain(400);
    check("drop_queue_empty", dropq.size(), 0);

    // di_en coincident with last issue, no pending
    for (int i = 0; i < NB; i++) frame_bins[i] = 14'(NB - i);
    fill_model();
    ca = cyc;
    drive_frame(6, -1);
    while (cyc < ca + 64) tick();
    for (int i = 0; i < NB; i++) frame_bins[i] = 14'(i * 3 - 20);
    fill_model();
    drive_frame(7, -1);
    drain(300);

    // Reset while bin 30 is on the output
    for (int i = 0; i < NB; i++) frame_bins[i] = 14'(i + 1);
    fill_model();
    ca = cyc;
    drive_frame(8, -1);
    while (cyc < ca + 34) tick();
    check("pre_reset_do_en", do_en, 1);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    sbq.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("post_reset_busy", busy, 0);
    drive_frame(9, -1);
    drain(200);

    // Idle
    repeat (1000) begin
      tick();
      check("idle_do_en", do_en, 0);
      check("idle_busy", busy, 0);
      check("idle_drop", drop_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
